// File: rtl/wm_cycle_sequencer_pkg.sv
// Shared definitions for the wash-cycle sequencer: phase codes, duration
// width and the per-phase actuator decode.
package wm_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned DUR_W   = 5;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_DRAIN = 3'd3,
    PH_RINSE = 3'd4,
    PH_SPIN  = 3'd5,
    PH_DONE  = 3'd6
  } phase_e;

  typedef struct packed {
    logic valve_in;
    logic valve_out;
    logic motor;
    logic motor_fast;
  } act_t;

  localparam act_t ACT_NONE  = '{1'b0, 1'b0, 1'b0, 1'b0};
  localparam act_t ACT_FILL  = '{1'b1, 1'b0, 1'b0, 1'b0};
  localparam act_t ACT_WASH  = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam act_t ACT_DRAIN = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam act_t ACT_RINSE = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam act_t ACT_SPIN  = '{1'b0, 1'b1, 1'b1, 1'b1};

  // Actuator pattern for an unpaused, non-empty phase.
  function automatic act_t act_decode(phase_e ph);
    case (ph)
      PH_FILL:  return ACT_FILL;
      PH_WASH:  return ACT_WASH;
      PH_DRAIN: return ACT_DRAIN;
      PH_RINSE: return ACT_RINSE;
      PH_SPIN:  return ACT_SPIN;
      default:  return ACT_NONE;
    endcase
  endfunction

  // True for the timed phases FILL..SPIN.
  function automatic logic is_running(phase_e ph);
    return (ph >= PH_FILL) && (ph <= PH_SPIN);
  endfunction

endpackage

// File: rtl/wm_cycle_sequencer_if.sv
// Control, preset and status signals between the controller and the sequencer.
interface wm_cycle_sequencer_if;
  import wm_pkg::*;

  logic             start;
  logic             pause;
  logic             abort;
  logic [DUR_W-1:0] wash_in;
  logic [DUR_W-1:0] rinse_in;
  logic [DUR_W-1:0] spin_in;
  logic [DUR_W-1:0] cloth_in;

  logic [PHASE_W-1:0] phase;
  logic [DUR_W-1:0]   remaining;
  logic               busy;
  logic               done;
  logic               valve_in;
  logic               valve_out;
  logic               motor;
  logic               motor_fast;

  modport master (
    output start, pause, abort, wash_in, rinse_in, spin_in, cloth_in,
    input  phase, remaining, busy, done, valve_in, valve_out, motor, motor_fast
  );

  modport slave (
    input  start, pause, abort, wash_in, rinse_in, spin_in, cloth_in,
    output phase, remaining, busy, done, valve_in, valve_out, motor, motor_fast
  );

endinterface

// File: rtl/wm_tick_prescaler.sv
// Divides clk down to one time-unit tick every TICK_DIV enabled cycles.
module wm_tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick on the last count of a unit while counting is enabled.
  assign tick_o = en_i && (cnt_q == CW'(TICK_DIV - 1));

  // Next count: clear wins, otherwise wrap after the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wm_cycle_sequencer.sv
// Runs one wash programme FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE from
// latched preset durations, with pause, abort-to-drain and actuator decode.
module wm_cycle_sequencer
  import wm_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned DRAIN_UNITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  wm_cycle_sequencer_if.slave  bus
);

  localparam logic [DUR_W-1:0] DRAIN_DUR = DUR_W'(DRAIN_UNITS);

  phase_e           phase_q, phase_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [DUR_W-1:0] wash_q, wash_d;
  logic [DUR_W-1:0] rinse_q, rinse_d;
  logic [DUR_W-1:0] spin_q, spin_d;
  logic             aborted_q, aborted_d;
  logic             busy_q, done_q;
  logic             load;
  logic             tick;
  logic             presc_en;
  act_t             act_c;

  assign presc_en = is_running(phase_q) && !bus.pause;

  wm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en_i   (presc_en),
    .clr_i  (load),
    .tick_o (tick)
  );

  // Next phase, remaining units and latched presets; load marks a phase entry.
  always_comb begin
    phase_d   = phase_q;
    rem_d     = rem_q;
    wash_d    = wash_q;
    rinse_d   = rinse_q;
    spin_d    = spin_q;
    aborted_d = aborted_q;
    load      = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        if (bus.start) begin
          wash_d  = bus.wash_in;
          rinse_d = bus.rinse_in;
          spin_d  = bus.spin_in;
          phase_d = PH_FILL;
          rem_d   = bus.cloth_in;
          load    = 1'b1;
        end
      end
      PH_FILL, PH_WASH, PH_DRAIN, PH_RINSE, PH_SPIN: begin
        if (bus.abort && !aborted_q) begin
          phase_d   = PH_DRAIN;
          rem_d     = DRAIN_DUR;
          aborted_d = 1'b1;
          load      = 1'b1;
        end else if (!bus.pause) begin
          // An empty phase advances after its single cycle.
          if ((rem_q == '0) || (tick && (rem_q == DUR_W'(1)))) begin
            load = 1'b1;
            case (phase_q)
              PH_FILL: begin
                phase_d = PH_WASH;
                rem_d   = wash_q;
              end
              PH_WASH: begin
                phase_d = PH_DRAIN;
                rem_d   = DRAIN_DUR;
              end
              PH_DRAIN: begin
                if (aborted_q) begin
                  phase_d   = PH_IDLE;
                  rem_d     = '0;
                  aborted_d = 1'b0;
                end else begin
                  phase_d = PH_RINSE;
                  rem_d   = rinse_q;
                end
              end
              PH_RINSE: begin
                phase_d = PH_SPIN;
                rem_d   = spin_q;
              end
              default: begin
                phase_d = PH_DONE;
                rem_d   = '0;
              end
            endcase
          end else if (tick) begin
            rem_d = rem_q - DUR_W'(1);
          end
        end
      end
      PH_DONE: begin
        phase_d = PH_IDLE;
        rem_d   = '0;
        load    = 1'b1;
      end
      default: begin
        phase_d   = PH_IDLE;
        rem_d     = '0;
        aborted_d = 1'b0;
        load      = 1'b1;
      end
    endcase
  end

  // Sequencer state and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= PH_IDLE;
      rem_q     <= '0;
      wash_q    <= '0;
      rinse_q   <= '0;
      spin_q    <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      wash_q    <= wash_d;
      rinse_q   <= rinse_d;
      spin_q    <= spin_d;
      aborted_q <= aborted_d;
      busy_q    <= is_running(phase_d);
      done_q    <= (phase_d == PH_DONE);
    end
  end

  // Actuators follow the phase directly; pause and empty phases keep them off.
  always_comb begin
    act_c = ACT_NONE;
    if (!bus.pause && (rem_q != '0)) begin
      act_c = act_decode(phase_q);
    end
  end

  assign bus.phase      = phase_q;
  assign bus.remaining  = rem_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.valve_in   = act_c.valve_in;
  assign bus.valve_out  = act_c.valve_out;
  assign bus.motor      = act_c.motor;
  assign bus.motor_fast = act_c.motor_fast;

endmodule

// File: doc/wm_cycle_sequencer.md
Name: wm_cycle_sequencer

Overview:
Runs one complete wash programme from the four 5-bit preset values (wash, rinse, spin, cloth) read out of the preset register bank. Sits directly downstream of the preset store and consumes its wash_out, rinse_out, spin_out and cloth_out buses. Steps through the fill, wash, drain, rinse and spin phases, timing each with a prescaled unit counter. Drives the valve and motor enables and reports status.

Parameters:
TICK_DIV, 4, clk cycles per time unit (≥2)
DRAIN_UNITS, 2, fixed drain-phase duration in time units (1..31)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begin programme (honoured only in IDLE)
pause  in  1  level; freeze programme while high
abort  in  1  single-cycle pulse; cancel programme and drain
wash_in  in  5  wash duration, units (from preset store wash_out)
rinse_in  in  5  rinse duration, units
spin_in  in  5  spin duration, units
cloth_in  in  5  cloth load; used as fill duration, units
phase  out  3  current phase code
remaining  out  5  units left in current phase
busy  out  1  high in FILL..SPIN
done  out  1  one-cycle pulse on normal completion
valve_in  out  1  inlet valve
valve_out  out  1  drain valve
motor  out  1  drum motor
motor_fast  out  1  spin-speed select

Behaviour:
- Phase codes: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6. Code 7 is unused and recovers to IDLE.
- Reset (async): phase=IDLE; remaining=0; prescaler=0; aborted flag=0; all outputs 0.
- IDLE with start=1: latch all four inputs into internal registers. Next cycle: phase=FILL, remaining=latched cloth.
- Input changes after the latch have no effect until the next start.
- Prescaler:
  - Counts 0..TICK_DIV-1 in phases 1..5 while pause=0.
  - tick is asserted when the count equals TICK_DIV-1. The count then wraps to 0.
  - Cleared to 0 on every phase entry.
- On tick with remaining>1: decrement remaining.
- On tick with remaining==1: advance to the next phase and load its duration.
- Result: a phase of N units lasts exactly N*TICK_DIV cycles.
- Normal sequence and durations: FILL(cloth) → WASH(wash) → DRAIN(DRAIN_UNITS) → RINSE(rinse) → SPIN(spin) → DONE → IDLE.
- Zero-duration phase: held for exactly one clk cycle with all actuator outputs 0, then the sequencer advances.
- DONE lasts one cycle with done=1, then IDLE with remaining=0.
- Actuator decode (pause=0):
  - FILL: valve_in
  - WASH: motor
  - DRAIN: valve_out
  - RINSE: valve_in + motor
  - SPIN: valve_out + motor + motor_fast
  - IDLE/DONE: none
- pause=1 in phases 1..5:
  - Prescaler and remaining are frozen.
  - All four actuator outputs are forced 0.
  - phase and busy are unchanged.
- abort in phases 1..5 (including while paused):
  - Next phase=DRAIN, remaining=DRAIN_UNITS, prescaler=0, aborted=1.
  - When the aborted DRAIN completes: go to IDLE with no DONE and no done pulse; clear aborted.
  - abort has priority over a simultaneous tick.
  - abort while aborted=1 is ignored.
  - abort in IDLE or DONE is ignored.
- start while busy or in DONE is ignored. start and abort together in IDLE: start wins.
- All outputs are registered except the actuator decode, which is combinational from phase and pause.

Decomposition:
- Shared package wm_pkg holds:
  - phase code constants (3-bit)
  - the 5-bit duration width constant
  - actuator decode constants per phase
- One natural sub-module: wm_tick_prescaler (enable, clear, tick out, parameter TICK_DIV).

Test Plan:
1. TICK_DIV=4, DRAIN_UNITS=2; cloth=2, wash=3, rinse=1, spin=2, pulse start → FILL 8, WASH 12, DRAIN 8, RINSE 4, SPIN 8 cycles. done pulses exactly 40 cycles after FILL entry, then phase=0.
2. wash=0, others as in 1 → WASH present for 1 cycle with motor=0; done 29 cycles after FILL entry.
3. pause high for 10 cycles in WASH with remaining=2 → remaining stays 2, motor=0 during pause, done delayed by exactly 10 cycles relative to scenario 1.
4. abort in RINSE (remaining=1) → DRAIN with remaining=2 for 8 cycles, valve_out=1, then IDLE; done never asserted. A second abort during that DRAIN is ignored.
5. Assert rst mid-SPIN → phase=0, remaining=0, all actuators 0 immediately without a clock edge. start pulsed during busy in a fresh run → no restart, timing unchanged.
6. Change wash_in from 3 to 31 one cycle after start → WASH still lasts 12 cycles.
